// File: rtl/finalsoc_midi_pkg.sv
// Shared definitions for the MIDI receive port: register map, bit positions,
// MIDI byte-class boundaries and the channel-message length rule.
package finalsoc_midi_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_LAST    = 2'd3;

   localparam int unsigned STAT_OVF_BIT    = 8;
   localparam int unsigned STAT_FERR_BIT   = 9;
   localparam int unsigned STAT_EMPTY_BIT  = 10;
   localparam int unsigned CTRL_IRQ_EN_BIT = 0;
   localparam int unsigned CTRL_RX_EN_BIT  = 1;

   localparam logic [7:0] MIDI_STATUS_MIN   = 8'h80;
   localparam logic [7:0] MIDI_SYSTEM_MIN   = 8'hF0;
   localparam logic [7:0] MIDI_REALTIME_MIN = 8'hF8;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP,
      UART_BREAK
   } uart_state_t;

   // Program change and channel pressure carry one data byte, all others two.
   function automatic logic [1:0] data_len(input logic [7:0] status);
      return ((status >= 8'hC0) && (status <= 8'hDF)) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/finalsoc_midi_uart_rx.sv
// MIDI serial deserializer: input synchronizer, 16x oversampling tick and
// receive FSM producing one-cycle byte_valid / frame_err pulses.
module finalsoc_midi_uart_rx
   import finalsoc_midi_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 31250
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_rx,
   input  logic       i_rx_en,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
   localparam int unsigned DIV     = (DIV_RAW > 1) ? DIV_RAW : 1;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   uart_state_t r_state, w_state_nxt;
   logic [1:0]       r_sync;
   logic             r_prev;
   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_tick, w_tick_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_vld, w_vld_nxt;
   logic             r_ferr, w_ferr_nxt;
   logic             w_rx, w_tick, w_div_clr;

   assign w_rx   = r_sync[1];
   assign w_tick = (r_div == DIV_W'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_state <= UART_IDLE;
         r_div   <= '0;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_vld   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_rx};
         r_prev  <= w_rx;
         r_state <= w_state_nxt;
         r_div   <= (w_div_clr || w_tick) ? '0 : r_div + 1'b1;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_vld   <= w_vld_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // Tick phase restarts on the start edge so tick 8 lands at mid-bit.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_vld_nxt   = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_div_clr   = 1'b0;
      if (!i_rx_en) begin
         w_state_nxt = UART_IDLE;
         w_div_clr   = 1'b1;
      end else begin
         case (r_state)
            UART_IDLE: begin
               if (r_prev && !w_rx) begin
                  w_state_nxt = UART_START;
                  w_tick_nxt  = '0;
                  w_div_clr   = 1'b1;
               end
            end
            UART_START: begin
               if (w_tick) begin
                  if (r_tick == 4'd7) begin
                     w_tick_nxt  = '0;
                     w_bit_nxt   = '0;
                     w_state_nxt = w_rx ? UART_IDLE : UART_DATA;
                  end else begin
                     w_tick_nxt = r_tick + 4'd1;
                  end
               end
            end
            UART_DATA: begin
               if (w_tick) begin
                  if (r_tick == 4'd15) begin
                     w_tick_nxt  = '0;
                     w_shift_nxt = {w_rx, r_shift[7:1]};
                     if (r_bit == 3'd7) w_state_nxt = UART_STOP;
                     else               w_bit_nxt   = r_bit + 3'd1;
                  end else begin
                     w_tick_nxt = r_tick + 4'd1;
                  end
               end
            end
            UART_STOP: begin
               if (w_tick) begin
                  if (r_tick == 4'd15) begin
                     w_tick_nxt = '0;
                     if (w_rx) begin
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = UART_IDLE;
                     end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = UART_BREAK;
                     end
                  end else begin
                     w_tick_nxt = r_tick + 4'd1;
                  end
               end
            end
            UART_BREAK: begin
               if (w_rx) w_state_nxt = UART_IDLE;
            end
            default: w_state_nxt = UART_IDLE;
         endcase
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_vld;
   assign o_frame_err  = r_ferr;

endmodule

// File: rtl/finalsoc_midi_rx.sv
// MIDI input port: UART front end, running-status parser, message FIFO and
// Avalon-MM register file for the CPU; drives the latest channel status out.
module finalsoc_midi_rx
   import finalsoc_midi_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 31250,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        midi_rx,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic [7:0]  status_out
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [7:0]  w_byte;
   logic        w_byte_valid, w_frame_err;
   logic [7:0]  r_run, r_d1;
   logic        r_idx;
   logic        r_push;
   logic [23:0] r_push_msg;
   logic [23:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic        r_ovf, r_ferr, r_irq_en, r_rx_en;
   logic        w_empty, w_full, w_pop, w_push_ok, w_wr_status, w_wr_control;
   logic [3:0]  w_cnt4;
   logic        w_unused_wdata;

   finalsoc_midi_uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_rx         (midi_rx),
      .i_rx_en      (r_rx_en),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err)
   );

   // Running status 0 doubles as "none": every channel status has bit 7 set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run      <= '0;
         r_d1       <= '0;
         r_idx      <= 1'b0;
         r_push     <= 1'b0;
         r_push_msg <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_byte_valid) begin
            if (w_byte >= MIDI_REALTIME_MIN) begin
               r_push     <= 1'b1;
               r_push_msg <= {w_byte, 16'h0000};
            end else if (w_byte >= MIDI_SYSTEM_MIN) begin
               r_run <= '0;
               r_idx <= 1'b0;
            end else if (w_byte >= MIDI_STATUS_MIN) begin
               r_run <= w_byte;
               r_idx <= 1'b0;
            end else if (r_run != '0) begin
               if (!r_idx && (data_len(r_run) == 2'd1)) begin
                  r_push     <= 1'b1;
                  r_push_msg <= {r_run, w_byte, 8'h00};
               end else if (!r_idx) begin
                  r_d1  <= w_byte;
                  r_idx <= 1'b1;
               end else begin
                  r_push     <= 1'b1;
                  r_push_msg <= {r_run, r_d1, w_byte};
                  r_idx      <= 1'b0;
               end
            end
         end
      end
   end

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop        = chipselect && !read_n && (address == ADDR_DATA) && !w_empty;
   assign w_push_ok    = r_push && (!w_full || w_pop);
   assign w_wr_status  = chipselect && !write_n && (address == ADDR_STATUS);
   assign w_wr_control = chipselect && !write_n && (address == ADDR_CONTROL);
   assign w_cnt4       = 4'(r_count);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= r_push_msg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_ferr   <= 1'b0;
         r_irq_en <= 1'b0;
         r_rx_en  <= 1'b1;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop)     r_rptr <= r_rptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A set in the same cycle as a clear write takes priority.
         if (r_push && w_full && !w_pop)                    r_ovf <= 1'b1;
         else if (w_wr_status && writedata[STAT_OVF_BIT])   r_ovf <= 1'b0;
         if (w_frame_err)                                   r_ferr <= 1'b1;
         else if (w_wr_status && writedata[STAT_FERR_BIT])  r_ferr <= 1'b0;
         if (w_wr_control) begin
            r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
            r_rx_en  <= writedata[CTRL_RX_EN_BIT];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: begin
            if (!w_empty) readdata = {1'b1, 7'b0, r_mem[r_rptr]};
         end
         ADDR_STATUS: begin
            readdata[3:0]            = w_cnt4;
            readdata[STAT_OVF_BIT]   = r_ovf;
            readdata[STAT_FERR_BIT]  = r_ferr;
            readdata[STAT_EMPTY_BIT] = w_empty;
         end
         ADDR_CONTROL: begin
            readdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            readdata[CTRL_RX_EN_BIT]  = r_rx_en;
         end
         ADDR_LAST: readdata[7:0] = r_run;
         default:   readdata = '0;
      endcase
   end

   assign irq            = r_irq_en && !w_empty;
   assign status_out     = r_run;
   assign w_unused_wdata = ^{writedata[31:10], writedata[7:2]};

endmodule
